// File: rtl/mult_share_sched.sv
// mult_share_sched: two-client round-robin scheduler around one shared
// shift-add unsigned multiplier (load, N add/shift pairs, done pulse).
module mult_share_sched #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [N-1:0]   a0,
  input  logic [N-1:0]   b0,
  input  logic           req1,
  input  logic [N-1:0]   a1,
  input  logic [N-1:0]   b1,
  output logic           busy,
  output logic           gnt0,
  output logic           gnt1,
  output logic [2*N-1:0] product,
  output logic           done0,
  output logic           done1
);
  localparam int PW = $clog2(N + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ADD   = 4'b0010,
    S_SHIFT = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_q;
  logic          r_c;
  logic [PW-1:0] r_p;
  logic          r_owner;
  logic          r_last;

  logic          w_any;
  logic          w_win;
  logic [N-1:0]  w_a_sel;
  logic [N-1:0]  w_b_sel;
  logic [N:0]    w_sum;

  assign w_any   = req0 | req1;
  // On a tie the client that was not served most recently wins.
  assign w_win   = (req0 & req1) ? ~r_last : req1;
  assign w_a_sel = w_win ? a1 : a0;
  assign w_b_sel = w_win ? b1 : b0;
  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};

  // Scheduler FSM and shift-add datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_b     <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_c     <= 1'b0;
      r_p     <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_b     <= w_a_sel;
            r_q     <= w_b_sel;
            r_a     <= '0;
            r_c     <= 1'b0;
            r_p     <= PW'(N);
            r_state <= S_ADD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ADD: begin
          if (r_q[0]) begin
            {r_c, r_a} <= w_sum;
          end else begin
            r_c <= r_c;
          end
          r_p     <= r_p - PW'(1);
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_c, r_a, r_q} <= {1'b0, r_c, r_a, r_q[N-1:1]};
          r_state         <= (r_p == '0) ? S_DONE : S_ADD;
        end
        S_DONE: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign gnt0    = busy & ~r_owner;
  assign gnt1    = busy & r_owner;
  assign product = {r_a, r_q};
  assign done0   = (r_state == S_DONE) & ~r_owner;
  assign done1   = (r_state == S_DONE) & r_owner;

endmodule

// File: tb/tb_mult_share_sched.sv
// Self-checking bench for mult_share_sched: directed and random operations
// against a behavioural model (a*b, round-robin tie rule, fixed latency).
module tb_mult_share_sched;
  localparam int N = 8;
  localparam int LAT = 2 * N + 1;

  logic           clk;
  logic           rst;
  logic           req0;
  logic [N-1:0]   a0;
  logic [N-1:0]   b0;
  logic           req1;
  logic [N-1:0]   a1;
  logic [N-1:0]   b1;
  logic           busy;
  logic           gnt0;
  logic           gnt1;
  logic [2*N-1:0] product;
  logic           done0;
  logic           done1;

  int n_checks = 0;
  int n_pass   = 0;
  logic m_last = 1'b1;

  mult_share_sched #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .busy(busy), .gnt0(gnt0), .gnt1(gnt1),
    .product(product), .done0(done0), .done1(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called in an IDLE cycle (cycle 0); returns in cycle LAT+1 (IDLE again).
  task automatic op(input logic r0, input logic r1,
                    input logic [N-1:0] x0, input logic [N-1:0] y0,
                    input logic [N-1:0] x1, input logic [N-1:0] y1,
                    input int drop_k, input int late_k, input bit keep,
                    input string tag);
    logic w;
    logic [2*N-1:0] expp;
    int gerr;
    int derr;
    req0 = r0; req1 = r1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    w    = (r0 && r1) ? ~m_last : r1;
    expp = w ? (16'(x1) * 16'(y1)) : (16'(x0) * 16'(y0));
    gerr = 0;
    derr = 0;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || gnt0 !== ~w || gnt1 !== w) gerr++;
      if (k < LAT && (done0 !== 1'b0 || done1 !== 1'b0)) derr++;
      if (k == drop_k) begin
        if (w) begin req1 = 1'b0; a1 = N'($urandom); b1 = N'($urandom); end
        else   begin req0 = 1'b0; a0 = N'($urandom); b0 = N'($urandom); end
      end
      if (k == late_k) begin
        if (w) req0 = 1'b1;
        else   req1 = 1'b1;
      end
    end
    chk({tag, "_gnt"}, gerr, 0);
    chk({tag, "_early_done"}, derr, 0);
    chk({tag, "_done_w"}, w ? done1 : done0, 1);
    chk({tag, "_done_l"}, w ? done0 : done1, 0);
    chk({tag, "_product"}, product, expp);
    m_last = w;
    if (w) req1 = 1'b0; else req0 = 1'b0;
    if (!keep) begin req0 = 1'b0; req1 = 1'b0; end
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, {busy, gnt0, gnt1, done0, done1}, 0);
  endtask

  initial begin
    int bad;
    logic [1:0] pat;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, gnt0, gnt1, done0, done1}, 0);
    chk("reset_product", product, 0);
    rst = 1'b0;

    op(1'b1, 1'b0, 8'd13, 8'd11, 8'd0, 8'd0, 0, 0, 1'b0, "basic_13x11");
    op(1'b1, 1'b1, 8'd5, 8'd7, 8'd9, 8'd3, 0, 0, 1'b1, "tie_c0");
    op(1'b0, 1'b1, 8'd5, 8'd7, 8'd9, 8'd3, 0, 0, 1'b0, "tie_c1");
    op(1'b0, 1'b1, 8'd0, 8'd0, 8'd255, 8'd255, 0, 0, 1'b0, "max_255x255");
    op(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd200, 0, 0, 1'b0, "zero_0x200");
    op(1'b1, 1'b0, 8'd12, 8'd12, 8'd0, 8'd0, 5, 0, 1'b0, "drop_12x12");
    op(1'b1, 1'b0, 8'd77, 8'd3, 8'd21, 8'd6, 0, 5, 1'b1, "late_c0");
    op(1'b0, 1'b1, 8'd77, 8'd3, 8'd21, 8'd6, 0, 0, 1'b0, "late_c1");

    for (int i = 0; i < 12; i++) begin
      pat = 2'($urandom_range(1, 3));
      op(pat[0], pat[1], N'($urandom), N'($urandom), N'($urandom), N'($urandom),
         0, 0, 1'b0, $sformatf("rand%0d", i));
    end

    // Abort an operation with reset in its cycle 8.
    req0 = 1'b1; a0 = 8'd12; b0 = 8'd12;
    repeat (8) begin @(posedge clk); #1; end
    chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_ctrl", {busy, gnt0, gnt1, done0, done1}, 0);
    chk("abort_product", product, 0);
    req0 = 1'b0;
    #1;
    rst = 1'b0;
    m_last = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) bad++;
    end
    chk("abort_no_done", bad, 0);
    op(1'b0, 1'b1, 8'd0, 8'd0, 8'd19, 8'd23, 0, 0, 1'b0, "after_abort");
    op(1'b1, 1'b1, 8'd200, 8'd3, 8'd4, 8'd250, 0, 0, 1'b0, "tie_after_c1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Sequencing controller plus shared shift-add datapath that lets two requesters time-share one N-bit unsigned multiplier. Arbitrates round-robin, loads the winner's operands, runs the add/shift loop for N iterations, returns the 2N-bit product and pulses that requester's done. Sits between client blocks and the multiplier core, replacing per-client multiplier instances.

## Interface
- N, 8, operand width (N >= 2); iteration counter width is $clog2(N+1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0  input  1  client 0 request; held high with operands stable until done0
- a0  input  N  client 0 multiplicand
- b0  input  N  client 0 multiplier
- req1  input  1  client 1 request
- a1  input  N  client 1 multiplicand
- b1  input  N  client 1 multiplier
- busy  output  1  high in any state other than IDLE
- gnt0  output  1  high while client 0 owns the unit (busy & owner==0)
- gnt1  output  1  high while client 1 owns the unit (busy & owner==1)
- product  output  2N  result {A,Q}; holds until the next load
- done0  output  1  one-cycle pulse, client 0 result valid
- done1  output  1  one-cycle pulse, client 1 result valid

## Operation
- State register is one-hot, 4 flops: IDLE, ADD, SHIFT, DONE. Reset state IDLE.
- Datapath registers: B (N), A (N), carry C (1), Q (N), P counter, owner (1), last (1).
- IDLE: if no req, stay. Else pick a winner: only one req -> that client; both -> client != last. On the edge: owner <= winner, B <= a_w, Q <= b_w, A <= 0, C <= 0, P <= N; go to ADD.
- ADD: if Q[0], {C,A} <= A + B (N+1-bit sum), else A, C unchanged; P <= P - 1; go to SHIFT.
- SHIFT: {C,A,Q} <= {1'b0,C,A,Q[N-1:1]} (logical right shift by one); if P == 0 go to DONE, else go to ADD.
- DONE: done_owner = 1 (combinational from state and owner); last <= owner; go to IDLE.
- Fixed latency; no early exit on zero operands.
- Requests are sampled only in IDLE; requests raised while busy wait.
- A req dropped mid-operation does not abort; the operation completes and done still pulses.
- Changing operands after the load edge has no effect on the result.
- Reset values: state IDLE, busy 0, gnt0/gnt1 0, done0/done1 0, product 0 (A, Q, C, B all 0), P 0, owner 0, last 1, so client 0 wins the first tie.
- Reset asserted mid-operation: all registers return to their reset values at once; no done pulse; the aborted request must be reissued.

## Timing
- Cycle 0: IDLE with a req high; the load occurs on the closing edge.
- Cycles 1..2N: alternating ADD and SHIFT, N pairs; busy and gnt are high.
- Cycle 2N+1: DONE; done_owner is high and product is valid (17 cycles after request sampling for N=8).
- Cycle 2N+2: IDLE. The client must drop req in the cycle after done, or it is taken as a new request.
- Back-to-back: if both reqs are held, the second client loads at the IDLE cycle 2N+2. Throughput is one product per 2N+2 cycles.
- product is stable from DONE until the next load edge.
- done0 and done1 are never high together; gnt0 and gnt1 are never high together.

## Test plan
- Reset then req0, a0=13, b0=11 -> gnt0 high in cycles 1..17; done0 pulses in cycle 17 for exactly one cycle; product=143; busy low in cycle 18.
- req0 and req1 both high from the first IDLE (a0=5,b0=7; a1=9,b1=3) -> client 0 served first (product 35, done0 in cycle 17), then client 1 loads in cycle 18 (product 27, done1 in cycle 35).
- a1=255, b1=255 (N=8) -> product 65025 (0xFE01); a1=0, b1=200 -> product 0, still 17-cycle latency.
- req0 dropped and a0/b0 changed in cycle 5 of an operation on 12*12 -> done0 still pulses in cycle 17 with product=144.
- rst pulsed in cycle 8 of an operation -> busy, gnt*, done*, product all 0 immediately; no done pulse; a fresh req1 then completes normally.
- req1 raised during client 0's operation -> no gnt1 until client 0's DONE has passed; client 1 loads at the next IDLE.
